// File: rtl/branch_unit_pkg.sv
// Shared CPU defines used by the branch unit: op encodings, tag width and the
// UNLOCKED tag, plus the branch FSM state type.
package branch_unit_pkg;

  localparam int SINST_W = 3;
  localparam int TAG_W   = 4;

  localparam logic [TAG_W-1:0] UNLOCKED = '0;

  // Encodings 6 and 7 are not branch ops and always resolve not-taken.
  localparam logic [SINST_W-1:0] BR_BEQ  = 3'd0;
  localparam logic [SINST_W-1:0] BR_BNE  = 3'd1;
  localparam logic [SINST_W-1:0] BR_BLT  = 3'd2;
  localparam logic [SINST_W-1:0] BR_BGE  = 3'd3;
  localparam logic [SINST_W-1:0] BR_BLTU = 3'd4;
  localparam logic [SINST_W-1:0] BR_BGEU = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    DONE     = 2'd3
  } br_state_e;

endpackage

// File: rtl/branch_unit_cmp.sv
// Combinational branch condition evaluator: signed and unsigned compares.
module branch_cmp
  import branch_unit_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [SINST_W-1:0] op,
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  output logic               taken
);

  logic eq, lt_s, lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = !lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: captures a ready branch from the reservation station,
// resolves it in one cycle and holds the redirect until fetch acks.
// Optional BRANCH_STATS_EN adds branch/taken handshake counters.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rs_busy,
  input  logic [ADDR_W-1:0]  rs_pc,
  input  logic [WORD_W-1:0]  rs_offset,
  input  logic [SINST_W-1:0] rs_op,
  input  logic [TAG_W-1:0]   rs_tagx,
  input  logic [TAG_W-1:0]   rs_tagy,
  input  logic [WORD_W-1:0]  rs_datax,
  input  logic [WORD_W-1:0]  rs_datay,
  output logic               busy_branch,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  input  logic               redirect_ack,
  output logic               taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_taken
`endif
);

  typedef struct packed {
    logic [SINST_W-1:0] op;
    logic [ADDR_W-1:0]  pc;
    logic [WORD_W-1:0]  offset;
    logic [WORD_W-1:0]  datax;
    logic [WORD_W-1:0]  datay;
  } br_entry_t;

  br_state_e         state, state_nxt;
  br_entry_t         ent;
  logic              capture, handshake, cmp_taken;
  logic [ADDR_W-1:0] off_ext, target;

  assign capture   = (state == IDLE) && rs_busy &&
                     (rs_tagx == UNLOCKED) && (rs_tagy == UNLOCKED);
  assign handshake = (state == REDIRECT) && redirect_ack;

  branch_cmp #(.WORD_W(WORD_W)) u_cmp (
    .op    (ent.op),
    .a     (ent.datax),
    .b     (ent.datay),
    .taken (cmp_taken)
  );

  // Offset is sign-extended (or truncated) to PC width; adds wrap naturally.
  assign off_ext = ADDR_W'($signed(ent.offset));
  assign target  = cmp_taken ? (ent.pc + off_ext) : (ent.pc + ADDR_W'(4));

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (capture) state_nxt = RESOLVE;
      RESOLVE:  state_nxt = REDIRECT;
      REDIRECT: if (redirect_ack) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Only the capture edge samples rs_*, so later tag/data churn is invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      taken          <= 1'b0;
    end else if (rdy) begin
      if (capture) begin
        ent.op     <= rs_op;
        ent.pc     <= rs_pc;
        ent.offset <= rs_offset;
        ent.datax  <= rs_datax;
        ent.datay  <= rs_datay;
      end
      if (state == RESOLVE) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= target;
        taken          <= cmp_taken;
      end
      if (handshake) redirect_valid <= 1'b0;
    end
  end

  always_comb begin
    busy_branch = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:             busy_branch = rs_busy;
        RESOLVE,REDIRECT: busy_branch = 1'b1;
        default:          busy_branch = 1'b0;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (rdy && handshake) begin
      stat_branches <= stat_branches + 32'd1;
      if (taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: driver pushes model results, the monitor
// checks each redirect and acts as the fetch-side ack responder.
module tb_branch_unit;
  import branch_unit_pkg::*;

  logic               clk = 1'b0;
  logic               rst, rdy, rs_busy;
  logic [31:0]        rs_pc, rs_offset, rs_datax, rs_datay;
  logic [SINST_W-1:0] rs_op;
  logic [TAG_W-1:0]   rs_tagx, rs_tagy;
  logic               busy_branch, redirect_valid, redirect_ack, taken;
  logic [31:0]        redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]        stat_branches, stat_taken;
`endif

  branch_unit #(.ADDR_W(32), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_busy(rs_busy), .rs_pc(rs_pc),
    .rs_offset(rs_offset), .rs_op(rs_op), .rs_tagx(rs_tagx), .rs_tagy(rs_tagy),
    .rs_datax(rs_datax), .rs_datay(rs_datay), .busy_branch(busy_branch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .taken(taken)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    int          issue;
    int          lat;
    int          vcyc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  int ack_delay = 0, vcnt = 0, done_cnt = 0, n_hs = 0, n_tk = 0;
  bit in_done = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] pc, off, x, y,
                                output logic tk, output logic [31:0] npc);
    case (op)
      BR_BEQ:  tk = (x == y);
      BR_BNE:  tk = (x != y);
      BR_BLT:  tk = ($signed(x) < $signed(y));
      BR_BGE:  tk = ($signed(x) >= $signed(y));
      BR_BLTU: tk = (x < y);
      BR_BGEU: tk = (x >= y);
      default: tk = 1'b0;
    endcase
    npc = tk ? pc + off : pc + 32'd4;
  endfunction

  // Monitor and ack responder; ack is random noise whenever no redirect is offered.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      vcnt = 0; in_done = 0; n_hs = 0; n_tk = 0;
      redirect_ack = 1'($urandom_range(0, 1));
    end else begin
      if (in_done) begin
        check("done_busy", busy_branch, 0);
        check("done_valid", redirect_valid, 0);
        in_done = 0;
      end
      if (redirect_valid) begin
        if (q.size() == 0) begin
          check("unexpected_redirect", q.size(), 1);
          redirect_ack = 1'b1;
        end else begin
          if (vcnt == 0) check("latency", cyc - q[0].issue, q[0].lat);
          check("redirect_pc", redirect_pc, q[0].pc);
          check("taken", taken, q[0].tk);
          check("busy_in_redirect", busy_branch, 1);
          redirect_ack = (vcnt >= ack_delay);
          vcnt++;
          if (redirect_ack) begin
            check("valid_cycles", vcnt, q[0].vcyc);
            n_hs++;
            if (q[0].tk) n_tk++;
            void'(q.pop_front());
            vcnt = 0;
            done_cnt++;
            in_done = 1;
          end
        end
      end else begin
        redirect_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] pc, off, x, y,
                       input int lock, input int stall, input int ad, input bit rst_mid);
    logic tk;
    logic [31:0] npc;
    exp_t e;
    int target, t;
    ack_delay = ad;
    target = done_cnt + 1;
    rs_op = op; rs_pc = pc; rs_offset = off; rs_datax = x; rs_datay = y;
    rs_busy = 1'b1; rs_tagy = UNLOCKED;
    for (int i = 0; i < lock; i++) begin
      rs_tagx = 4'($urandom_range(1, 15));
      #1;
      check("lock_busy", busy_branch, 1);
      check("lock_no_redirect", redirect_valid, 0);
      @(posedge clk); #1;
    end
    rs_tagx = UNLOCKED;
    model(op, pc, off, x, y, tk, npc);
    e.pc = npc; e.tk = tk; e.issue = cyc; e.lat = 2 + stall; e.vcyc = ad + 1;
    q.push_back(e);
    @(posedge clk); #1;
    rs_busy = 1'b0;
    rs_tagx = 4'($urandom); rs_tagy = 4'($urandom);
    rs_datax = $urandom; rs_datay = $urandom; rs_op = 3'($urandom); rs_pc = $urandom;
    if (stall > 0) begin
      rdy = 1'b0;
      repeat (stall) @(posedge clk);
      #1 rdy = 1'b1;
    end
    if (!rst_mid) begin
      t = 0;
      while (done_cnt < target && t < 200) begin @(posedge clk); t++; end
      if (done_cnt < target) check("handshake_timeout", done_cnt, target);
      #1; @(posedge clk); #1;
    end else begin
      t = 0;
      while (!redirect_valid && t < 20) begin @(posedge clk); #1; t++; end
      check("reached_redirect", redirect_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_valid", redirect_valid, 0);
      check("rst_pc", redirect_pc, 0);
      check("rst_busy", busy_branch, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    rst = 1'b1; rdy = 1'b1; rs_busy = 1'b1;
    rs_pc = '0; rs_offset = '0; rs_datax = '0; rs_datay = '0; rs_op = '0;
    rs_tagx = UNLOCKED; rs_tagy = UNLOCKED;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", redirect_valid, 0);
    check("reset_pc", redirect_pc, 0);
    check("reset_taken", taken, 0);
    check("reset_busy", busy_branch, 0);
    rs_busy = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    issue(BR_BEQ,  32'h100, 32'h20, 32'd5, 32'd5, 0, 0, 0, 0);
    issue(BR_BLT,  32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    issue(BR_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    issue(BR_BGE,  32'h300, 32'hFFFF_FFF0, 32'd7, 32'd7, 3, 0, 1, 0);
    issue(BR_BNE,  32'h400, 32'h8, 32'd1, 32'd2, 0, 0, 5, 0);
    issue(BR_BGEU, 32'h500, 32'h10, 32'd9, 32'd3, 0, 3, 0, 0);
    issue(3'd6,    32'h600, 32'h10, 32'd1, 32'd1, 0, 0, 0, 0);
    issue(3'd7,    32'h700, 32'h10, 32'd1, 32'd2, 0, 0, 2, 0);
    issue(BR_BNE,  32'hFFFF_FFFC, 32'h10, 32'd4, 32'd4, 0, 0, 0, 0);

    // Unlocked tags but no valid entry: nothing may be captured.
    rs_busy = 1'b0; rs_tagx = UNLOCKED; rs_tagy = UNLOCKED;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_busy", busy_branch, 0);
      check("idle_no_redirect", redirect_valid, 0);
    end

    issue(BR_BEQ, 32'h800, 32'h40, 32'd3, 32'd3, 0, 0, 50, 1);

    issue(BR_BEQ, 32'h900, 32'h4, 32'd1, 32'd1, 0, 0, 0, 0);
    issue(BR_BNE, 32'hA00, 32'h8, 32'd1, 32'd2, 0, 0, 1, 0);
    issue(BR_BLT, 32'hB00, 32'h8, 32'd5, 32'd2, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
    check("stat_branches_3", stat_branches, 3);
    check("stat_taken_2", stat_taken, 2);
`endif

    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x + 32'd1;
        2: y = ~x;
        default: y = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, x, y,
            $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? 1 : 0,
            $urandom_range(0, 3), 0);
    end

`ifdef BRANCH_STATS_EN
    check("stat_branches_final", stat_branches, n_hs);
    check("stat_taken_final", stat_taken, n_tk);
`endif
    check("scoreboard_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
